// File: rtl/arb_pkg.sv
// Shared types and sizes for the round-robin decoder arbiter.
// Imported by rr_pick and rr_decoder_arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate by ptr,
// priority-encode the lowest set bit, un-rotate.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]     w_off;

  // bit i of w_rot is requester (ptr+i) mod 4
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[NUM_REQ-1:0];

  // smallest distance from ptr wins
  always_comb begin
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDX_W'(i);
    end
  end

  assign idx   = ptr + w_off;
  assign valid = |req;

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter driving a 2-to-4 decoder's address/enable.
// Optional tenure limit enabled by defining ARB_TIMEOUT_EN.
module rr_decoder_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
)(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic               address0,
  output logic               address1,
  output logic               enable,
  output logic               busy
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W-1:0] r_addr;
  logic [IDX_W-1:0] w_addr_nxt;
  logic             r_en;
  logic             r_busy;
  logic             w_grant_nxt;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_valid;
  logic             w_owner_req;
  logic             w_timeout;

  rr_pick u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .idx   (w_pick_idx),
    .valid (w_pick_valid)
  );

  assign w_owner_req = req[r_addr];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  // tenure counter: zero in IDLE, counts GRANT cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_cnt == CNT_W'(HOLD_MAX - 1));
`else
  logic w_unused_cfg;

  assign w_unused_cfg = ^{HOLD_MAX[0], CNT_W[0]};
  assign w_timeout    = 1'b0;
`endif

  // next-state, next pointer and next address
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_addr_nxt  = r_addr;
    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = GRANT;
          w_addr_nxt  = w_pick_idx;
        end
      end
      GRANT: begin
        if (!w_owner_req || w_timeout) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = r_addr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_grant_nxt = (w_state_nxt == GRANT);
  end

  // state, pointer and registered decoder outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_addr  <= w_addr_nxt;
      r_en    <= w_grant_nxt;
      r_busy  <= w_grant_nxt;
    end
  end

  assign address0 = r_addr[0];
  assign address1 = r_addr[1];
  assign enable   = r_en;
  assign busy     = r_busy;

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- Four-requester round-robin arbiter that sits directly upstream of the 2-to-4 decoder.
- Produces the decoder's address0/address1/enable inputs.
- The decoder's one-hot outputs act as the grant lines back to requesters.
- Holds a grant until the owner drops its request; fair rotation prevents starvation.

Parameters:
- HOLD_MAX, 8: maximum consecutive GRANT cycles for one owner. Used only when ARB_TIMEOUT_EN is defined. Legal range 1..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i is requester i, level-sensitive.
- address0  output  1  LSB of granted index, to decoder address0.
- address1  output  1  MSB of granted index, to decoder address1.
- enable  output  1  grant valid, to decoder enable.
- busy  output  1  high while in GRANT state.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, reset).
- All outputs are registered.
- Reset values: address0=0, address1=0, enable=0, busy=0, state=IDLE, ptr=0, hold counter=0.
- Reset asserted mid-grant: enable drops at the next edge; ptr returns to 0; no grant survives reset.
- ptr (2 bits) is the highest-priority index.
  - Search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4; wraps 3→0.
- IDLE:
  - If req != 0 at an edge, latch the first set index in search order into {address1,address0}.
  - Same edge: set enable=1, busy=1, go to GRANT.
  - Latency: req sampled at edge n, enable high after edge n.
  - If req == 0, stay in IDLE with enable=0; address holds its last value.
- GRANT, owner = {address1,address0}:
  - If req[owner]=1, stay; the grant is held.
  - If req[owner]=0 at an edge: enable=0, busy=0, ptr=owner+1 mod 4, go to IDLE.
  - This leaves one mandatory bubble cycle between grants; there is no back-to-back grant.
- Requests from non-owners during GRANT are ignored; they remain pending as levels.
- Simultaneous requests in IDLE: lowest distance from ptr wins.
  - Example: ptr=2, req=4'b1011 → grant index 3.
- A requester that drops req before being granted is simply not considered.
- The address is stable for the whole GRANT, so the decoder output is glitch-free, one-hot and held.
- Without ARB_TIMEOUT_EN, a single requester holding req indefinitely keeps the grant indefinitely.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - The hold counter clears on GRANT entry and increments every GRANT cycle.
  - When the counter reaches HOLD_MAX-1 and req[owner] is still 1, the next edge forces enable=0, busy=0, ptr=owner+1, go to IDLE.
  - Result: maximum tenure is exactly HOLD_MAX cycles of enable=1.
  - A preempted owner still requesting is re-arbitrated normally, at lowest priority.
- Undefined:
  - No counter logic is present.
  - HOLD_MAX and CNT_W are unused.
  - Release happens only when the owner drops req.

Decomposition:
- Shared package arb_pkg:
  - NUM_REQ=4 and IDX_W=2.
  - State typedef arb_state_t {IDLE=1'b0, GRANT=1'b1}.
- One sub-module: rr_pick, purely combinational.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: idx[1:0], valid.
  - Implements rotate, priority-encode, un-rotate.
- The top contains the FSM, ptr register, output registers and optional counter.

Test Plan:
- Reset then req=4'b0000 for 5 cycles → enable=0, busy=0, address=00 throughout.
- From reset (ptr=0), req=4'b0100 held 3 cycles then 0 → enable high 3 cycles with address=10; bubble cycle; ptr=3.
- ptr=3, req=4'b1111 held; each owner drops its bit one cycle after grant → grant order 3,0,1,2, each separated by an enable=0 bubble.
- Assert reset during GRANT owner=1 → next edge enable=0, busy=0, ptr=0. After release, req=4'b0011 → grant 0.
- With ARB_TIMEOUT_EN and HOLD_MAX=4, req=4'b0011 constant:
  - enable high exactly 4 cycles for index 0, then a bubble.
  - Then index 1 for 4 cycles, then a bubble.
  - Alternation continues.
- Same stimulus without ARB_TIMEOUT_EN → index 0 held indefinitely; index 1 never granted.
